led_status_pwm: RTL and testbench

- Status-to-LED stage between the deflate self-test bench and the iCE40 RGB LED driver primitive on the UP5K chip top.
- Consumes the bench's busy/done/pass/error-code status and produces the three PWM drive bits (red, green, blue) fed to the driver's PWM inputs.
- Encodes test progress as steady, blinking or coded-flash colour patterns at a low duty, so a person can read the result by eye without a UART.

---
 rtl/led_status_pwm.sv | 193 +++++++++++++++++++
 tb/tb_led_status_pwm.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/led_status_pwm.sv
// led_status_pwm: maps self-test status (busy/done/pass/error code) to
// low-duty RGB PWM bits for the iCE40 RGB LED driver.
//   clk        system clock (HFOSC)
//   reset      synchronous active-low reset
//   i_busy     level, test in progress
//   i_done     one-cycle pulse, test finished
//   i_pass     result, valid with i_done
//   i_err_code failure code, valid with i_done
//   led0/1/2   red/green/blue PWM bits (registered)
//   o_state    FSM state: 0 IDLE, 1 RUN, 2 PASS, 3 FAIL
module led_status_pwm #(
    parameter int unsigned TICK_DIV  = 48000,
    parameter int unsigned DIM_DUTY  = 8,
    parameter int unsigned ON_DUTY   = 64,
    parameter int unsigned RUN_HALF  = 250,
    parameter int unsigned FLASH_ON  = 200,
    parameter int unsigned FLASH_OFF = 300,
    parameter int unsigned GAP_TICKS = 1500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_busy,
    input  logic       i_done,
    input  logic       i_pass,
    input  logic [3:0] i_err_code,
    output logic       led0,
    output logic       led1,
    output logic       led2,
    output logic [1:0] o_state
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned CNT_MAX = max2(max2(RUN_HALF, FLASH_ON), max2(FLASH_OFF, GAP_TICKS));
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam int unsigned PW      = $clog2(TICK_DIV);
    localparam logic [7:0]  DIM_D   = 8'(DIM_DUTY);
    localparam logic [7:0]  ON_D    = 8'(ON_DUTY);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FS_FLASH = 2'd0,
        FS_SPACE = 2'd1,
        FS_GAP   = 2'd2
    } fsub_t;

    state_t          state;
    fsub_t           fsub;
    logic [7:0]      pwm_cnt;
    logic [PW-1:0]   presc;
    logic            tick_c;
    logic [CW-1:0]   run_cnt;
    logic            blue_lit;
    logic [CW-1:0]   ph_cnt;
    logic [3:0]      flash_cnt;
    logic [3:0]      err_code;
    logic [7:0]      duty0_c;
    logic [7:0]      duty1_c;
    logic [7:0]      duty2_c;

    assign tick_c  = (presc == PW'(TICK_DIV - 1));
    assign o_state = state;

    // Free-running PWM counter and tick prescaler; independent of FSM state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pwm_cnt <= 8'd0;
            presc   <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            presc   <= tick_c ? '0 : presc + PW'(1);
        end
    end

    // Status FSM with pattern counters; PASS/FAIL are left only by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            fsub      <= FS_FLASH;
            run_cnt   <= '0;
            blue_lit  <= 1'b0;
            ph_cnt    <= '0;
            flash_cnt <= 4'd0;
            err_code  <= 4'd0;
        end else if ((state == ST_IDLE || state == ST_RUN) && i_done) begin
            // done outranks busy in the same cycle
            if (i_pass) begin
                state <= ST_PASS;
            end else begin
                state     <= ST_FAIL;
                err_code  <= i_err_code;
                fsub      <= FS_FLASH;
                ph_cnt    <= '0;
                flash_cnt <= 4'd0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_busy) begin
                        state    <= ST_RUN;
                        run_cnt  <= '0;
                        blue_lit <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (tick_c) begin
                        if (run_cnt == CW'(RUN_HALF - 1)) begin
                            run_cnt  <= '0;
                            blue_lit <= ~blue_lit;
                        end else begin
                            run_cnt <= run_cnt + CW'(1);
                        end
                    end
                end
                ST_PASS: ;
                ST_FAIL: begin
                    // code 0 is steady red, so its counters stay frozen
                    if (tick_c && err_code != 4'd0) begin
                        case (fsub)
                            FS_FLASH: begin
                                if (ph_cnt == CW'(FLASH_ON - 1)) begin
                                    ph_cnt    <= '0;
                                    flash_cnt <= flash_cnt + 4'd1;
                                    fsub      <= (flash_cnt + 4'd1 == err_code) ? FS_GAP : FS_SPACE;
                                end else begin
                                    ph_cnt <= ph_cnt + CW'(1);
                                end
                            end
                            FS_SPACE: begin
                                if (ph_cnt == CW'(FLASH_OFF - 1)) begin
                                    ph_cnt <= '0;
                                    fsub   <= FS_FLASH;
                                end else begin
                                    ph_cnt <= ph_cnt + CW'(1);
                                end
                            end
                            default: begin
                                if (ph_cnt == CW'(GAP_TICKS - 1)) begin
                                    ph_cnt    <= '0;
                                    flash_cnt <= 4'd0;
                                    fsub      <= FS_FLASH;
                                end else begin
                                    ph_cnt <= ph_cnt + CW'(1);
                                end
                            end
                        endcase
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Duty selection from current state; unlit colours get duty 0.
    always_comb begin
        duty0_c = 8'd0;
        duty1_c = 8'd0;
        duty2_c = 8'd0;
        case (state)
            ST_IDLE: duty2_c = DIM_D;
            ST_RUN:  duty2_c = blue_lit ? ON_D : 8'd0;
            ST_PASS: duty1_c = ON_D;
            ST_FAIL: begin
                if (err_code == 4'd0 || fsub == FS_FLASH) begin
                    duty0_c = ON_D;
                end
            end
            default: ;
        endcase
    end

    // Registered PWM compares.
    always_ff @(posedge clk) begin
        if (!reset) begin
            led0 <= 1'b0;
            led1 <= 1'b0;
            led2 <= 1'b0;
        end else begin
            led0 <= (pwm_cnt < duty0_c);
            led1 <= (pwm_cnt < duty1_c);
            led2 <= (pwm_cnt < duty2_c);
        end
    end

endmodule

// File: tb/tb_led_status_pwm.sv
// tb_led_status_pwm: directed bench for led_status_pwm with shortened
// pattern timing (TICK_DIV=4, RUN_HALF=2, FLASH_ON=2, FLASH_OFF=1, GAP_TICKS=3).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_led_status_pwm;

    logic       clk;
    logic       reset;
    logic       i_busy;
    logic       i_done;
    logic       i_pass;
    logic [3:0] i_err_code;
    logic       led0;
    logic       led1;
    logic       led2;
    logic [1:0] o_state;

    int vecs;
    int errs;

    led_status_pwm #(
        .TICK_DIV (4),
        .DIM_DUTY (8),
        .ON_DUTY  (64),
        .RUN_HALF (2),
        .FLASH_ON (2),
        .FLASH_OFF(1),
        .GAP_TICKS(3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_busy    (i_busy),
        .i_done    (i_done),
        .i_pass    (i_pass),
        .i_err_code(i_err_code),
        .led0      (led0),
        .led1      (led1),
        .led2      (led2),
        .o_state   (o_state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Count high cycles of each LED over 256 clocks.
    task automatic count256(output int c0, output int c1, output int c2);
        c0 = 0;
        c1 = 0;
        c2 = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            if (led0) c0++;
            if (led1) c1++;
            if (led2) c2++;
        end
    endtask

    initial begin
        int   c0, c1, c2;
        logic pat [11];
        int   exp_led;

        pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs       = 0;
        errs       = 0;
        clk        = 1'b0;
        reset      = 1'b0;
        i_busy     = 1'b0;
        i_done     = 1'b0;
        i_pass     = 1'b0;
        i_err_code = 4'd0;

        // Reset held 5 clocks
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rst_leds", int'({led0, led1, led2}), 0);
            chk("rst_state", int'(o_state), 0);
        end
        reset = 1'b1;

        // IDLE dim blue: edges 1..256 see pwm 0..255
        count256(c0, c1, c2);
        chk("idle_led2_cnt", c2, 8);
        chk("idle_led0_cnt", c0, 0);
        chk("idle_led1_cnt", c1, 0);

        // Enter RUN on edge 260, aligned to a tick
        step(); step(); step();
        chk("idle_state", int'(o_state), 0);
        i_busy = 1'b1;
        step();
        i_busy = 1'b0;
        chk("run_state", int'(o_state), 1);

        // Edges 261..292: pwm 4..35, blue lit 8 clk, dark 8 clk
        for (int k = 261; k <= 292; k++) begin
            step();
            exp_led = (((k - 261) / 8) % 2 == 0) ? 1 : 0;
            chk("run_blink_led2", int'(led2), exp_led);
            chk("run_red_green", int'({led0, led1}), 0);
        end

        // PASS
        i_done = 1'b1;
        i_pass = 1'b1;
        step();
        i_done = 1'b0;
        i_pass = 1'b0;
        chk("pass_state", int'(o_state), 2);
        count256(c0, c1, c2);
        chk("pass_led1_cnt", c1, 64);
        chk("pass_led0_cnt", c0, 0);
        chk("pass_led2_cnt", c2, 0);
        i_busy = 1'b1;
        step();
        i_busy = 1'b0;
        chk("pass_sticky_busy", int'(o_state), 2);
        i_done     = 1'b1;
        i_err_code = 4'd5;
        step();
        i_done     = 1'b0;
        i_err_code = 4'd0;
        step();
        chk("pass_sticky_done", int'(o_state), 2);

        // Reset out of PASS
        reset = 1'b0;
        step();
        chk("rst2_state", int'(o_state), 0);
        step();
        reset = 1'b1;

        // FAIL code 3 entered on edge 4 (tick-aligned)
        step(); step(); step();
        i_done     = 1'b1;
        i_err_code = 4'd3;
        step();
        i_done     = 1'b0;
        i_err_code = 4'd0;
        chk("fail_state", int'(o_state), 3);

        // Edges 5..60: pwm 4..59, red follows per-tick flash pattern
        for (int k = 5; k <= 60; k++) begin
            step();
            exp_led = pat[((k - 5) / 4) % 11] ? 1 : 0;
            chk("fail3_led0", int'(led0), exp_led);
            chk("fail3_green_blue", int'({led1, led2}), 0);
        end

        // Reset mid-flash (FLASH active after edge 60)
        reset = 1'b0;
        step();
        chk("midrst_state", int'(o_state), 0);
        chk("midrst_leds", int'({led0, led1, led2}), 0);
        reset = 1'b1;
        count256(c0, c1, c2);
        chk("midrst_led2_cnt", c2, 8);
        chk("midrst_led0_cnt", c0, 0);
        chk("midrst_led1_cnt", c1, 0);

        // busy and done together with code 0: straight to FAIL, steady red
        i_busy     = 1'b1;
        i_done     = 1'b1;
        i_pass     = 1'b0;
        i_err_code = 4'd0;
        step();
        i_busy = 1'b0;
        i_done = 1'b0;
        chk("sim_state", int'(o_state), 3);
        count256(c0, c1, c2);
        chk("code0_led0_cnt", c0, 64);
        chk("code0_led1_cnt", c1, 0);
        chk("code0_led2_cnt", c2, 0);
        chk("code0_state", int'(o_state), 3);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
